third_pipe: RTL and testbench
=============================

Name: third_pipe

Overview:
EX/MEM pipeline register. Sits directly downstream of the ID/EX register and the execute datapath, and feeds the data-memory stage. It captures the ALU result, store data, destination register and control bits on the falling edge of CLK. It adds stall/flush handling, a valid bit, single-shot branch/jump redirect generation and a saturating bubble counter.

Parameters:
DATA_W, 32, width of datapath words (ALU result, store data, PC values)
REG_AW, 5, register-file address width
CNT_W, 16, width of the bubble performance counter

Ports:
CLK  input  1  clock; all state updates on the falling edge of CLK, matching the other pipeline registers
RST  input  1  synchronous, active-high reset, sampled on the falling edge of CLK
stall3  input  1  hold the current contents; upstream data is ignored
flush3  input  1  insert a bubble in place of the upstream instruction
valid3  input  1  upstream slot holds a real instruction
ALUresult3  input  DATA_W  execute-stage ALU result
zero3  input  1  ALU zero flag
Rdata23  input  DATA_W  forwarded store data (rt value)
Wreg_addr3  input  REG_AW  destination register
target3  input  DATA_W  branch or jump target computed in EX
JtoPC3, Branch3, RegWrite3, MemWrite3, MemRead3, MemtoReg3  input  1 each  control bits from ID/EX
ALUresult3_4  output  DATA_W  registered ALU result (memory address or writeback value)
Wdata3_4  output  DATA_W  registered store data
Wreg_addr3_4  output  REG_AW  registered destination
RegWrite3_4, MemWrite3_4, MemRead3_4, MemtoReg3_4  output  1 each  registered control bits, gated by valid
valid3_4  output  1  slot holds a real instruction
redirect3_4  output  1  one-cycle pulse: taken branch or jump
redirect_PC3_4  output  DATA_W  target accompanying the redirect pulse
bubble_cnt  output  CNT_W  number of bubbles inserted since reset (saturating)

Behaviour:
- Reset (RST=1 at a falling edge): every output goes to 0, including the internal redirect_done flag. Reset overrides stall3 and flush3.
- Priority at each falling edge is RST > flush3 > stall3 > load.
- Load (no stall, no flush): all data and control fields are captured from their inputs; valid3_4 <= valid3. Latency is one falling edge.
- Redirect on load:
  - taken = valid3 & ((Branch3 & zero3) | JtoPC3).
  - redirect3_4 <= taken; redirect_PC3_4 <= target3 when taken, otherwise it holds its previous value.
  - redirect_done <= taken.
- Flush:
  - valid3_4, RegWrite3_4, MemWrite3_4, MemRead3_4, MemtoReg3_4, redirect3_4 and redirect_done all go to 0.
  - The data fields (ALUresult3_4, Wdata3_4, Wreg_addr3_4) are don't-care; the implementation holds them.
  - bubble_cnt increments by 1 and saturates at all-ones (no wrap).
- Stall:
  - All fields hold, except redirect3_4, which goes to 0.
  - The held instruction never re-pulses a redirect: redirect_done stays set, and redirect3_4 is high for exactly one edge per instruction no matter how long the stall lasts.
- Flush and stall together: flush wins, and the counter increments.
- Load with valid3=0: valid3_4 goes to 0 and all control outputs are forced to 0. This counts as an upstream bubble, not an inserted one, so bubble_cnt does not change.
- The control outputs are always the registered control ANDed with valid3_4, so an invalid slot can never write memory or the register file.
- Stores: MemWrite3_4=1 implies Wdata3_4 equals the Rdata23 value captured on that edge.

Decomposition:
- Shared package pipe_pkg holds:
  - the DATA_W and REG_AW defaults;
  - a packed control-bundle typedef {RegWrite, MemWrite, MemRead, MemtoReg}, also reused by the MEM/WB register;
  - the constant CTRL_BUBBLE = 0.
- One natural sub-module, sat_counter (CNT_W, inc, clear). It is also reused for the stall counters in the hazard unit.

Test Plan:
- Reset: drive random inputs, assert RST for 2 edges -> all outputs 0 and bubble_cnt=0; on release with valid3=1, RegWrite3=1, ALUresult3=0x0000_0010 -> one edge later ALUresult3_4=0x10 and RegWrite3_4=1.
- Taken branch under stall: load Branch3=1, zero3=1, target3=0x0040_0020, then stall3=1 for 3 edges -> redirect3_4=1 for exactly one edge, redirect_PC3_4 holds 0x0040_0020, and all other fields stay held.
- Not taken: Branch3=1, zero3=0 -> redirect3_4 stays 0. JtoPC3=1, valid3=0 -> redirect3_4 stays 0.
- Flush over stall: an instruction with MemWrite3=1 is held, then stall3=1 and flush3=1 together -> MemWrite3_4=0, valid3_4=0, bubble_cnt +1.
- Counter saturation: CNT_W=4, flush for 20 edges -> bubble_cnt=15 and stays there; an RST edge -> 0.
- Store data: valid3=1, MemWrite3=1, Rdata23=0xDEAD_BEEF, ALUresult3=0x1000_0004 -> Wdata3_4=0xDEADBEEF, ALUresult3_4=0x10000004, MemWrite3_4=1.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline registers of the five-stage core.
// Holds the default datapath and register-address widths, the packed
// control bundle carried from EX through MEM into WB, and the bubble value
// for that bundle.
package pipe_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int REG_AW_DEF = 5;

    // Control bits that reach the memory and writeback stages.
    // The MEM/WB register carries the same bundle.
    typedef struct packed {
        logic reg_write;
        logic mem_write;
        logic mem_read;
        logic mem_to_reg;
    } ctrl_t;

    // A bubble must never write memory or the register file.
    localparam ctrl_t CTRL_BUBBLE = '0;

endpackage : pipe_pkg

// File: rtl/sat_counter.sv
// Saturating up-counter used for pipeline performance statistics
// (bubble count here, stall counts in the hazard unit).
// State updates on the falling edge of clk, like the pipeline registers.
// Ports:
//   clk   - clock (falling edge active)
//   clear - synchronous clear to zero, dominates inc
//   inc   - add one, sticks at all-ones instead of wrapping
//   count - current counter value
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             clear,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (inc && (count_q != {CNT_W{1'b1}})) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(negedge clk) begin
        if (clear) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule : sat_counter

// File: rtl/third_pipe.sv
// EX/MEM pipeline register.
// Captures the execute-stage results and control on the falling edge of CLK,
// with flush (bubble insertion), stall (hold), a valid bit, a single-shot
// branch/jump redirect pulse and a saturating count of inserted bubbles.
// Ports:
//   CLK, RST                     - clock (falling edge) and synchronous reset
//   stall3, flush3, valid3       - hold / bubble / upstream-valid controls
//   ALUresult3, zero3, Rdata23, Wreg_addr3, target3 - EX datapath inputs
//   JtoPC3, Branch3, RegWrite3, MemWrite3, MemRead3, MemtoReg3 - ID/EX control
//   ALUresult3_4, Wdata3_4, Wreg_addr3_4 - registered datapath to MEM
//   RegWrite3_4 .. MemtoReg3_4   - registered control, gated by valid3_4
//   valid3_4                     - slot holds a real instruction
//   redirect3_4, redirect_PC3_4  - one-edge redirect pulse and its target
//   bubble_cnt                   - saturating count of flush-inserted bubbles
module third_pipe
    import pipe_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int REG_AW = REG_AW_DEF,
    parameter int CNT_W  = 16
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              stall3,
    input  logic              flush3,
    input  logic              valid3,
    input  logic [DATA_W-1:0] ALUresult3,
    input  logic              zero3,
    input  logic [DATA_W-1:0] Rdata23,
    input  logic [REG_AW-1:0] Wreg_addr3,
    input  logic [DATA_W-1:0] target3,
    input  logic              JtoPC3,
    input  logic              Branch3,
    input  logic              RegWrite3,
    input  logic              MemWrite3,
    input  logic              MemRead3,
    input  logic              MemtoReg3,
    output logic [DATA_W-1:0] ALUresult3_4,
    output logic [DATA_W-1:0] Wdata3_4,
    output logic [REG_AW-1:0] Wreg_addr3_4,
    output logic              RegWrite3_4,
    output logic              MemWrite3_4,
    output logic              MemRead3_4,
    output logic              MemtoReg3_4,
    output logic              valid3_4,
    output logic              redirect3_4,
    output logic [DATA_W-1:0] redirect_PC3_4,
    output logic [CNT_W-1:0]  bubble_cnt
);

    logic [DATA_W-1:0] alu_q, alu_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [REG_AW-1:0] waddr_q, waddr_d;
    ctrl_t             ctrl_q, ctrl_d;
    logic              valid_q, valid_d;
    logic              redirect_q, redirect_d;
    logic [DATA_W-1:0] redirect_pc_q, redirect_pc_d;
    logic              redirect_done_q, redirect_done_d;

    ctrl_t ctrl_in;
    logic  taken;

    assign ctrl_in = '{reg_write: RegWrite3, mem_write: MemWrite3,
                       mem_read: MemRead3, mem_to_reg: MemtoReg3};
    assign taken   = valid3 & ((Branch3 & zero3) | JtoPC3);

    always_comb begin
        alu_d           = alu_q;
        wdata_d         = wdata_q;
        waddr_d         = waddr_q;
        ctrl_d          = ctrl_q;
        valid_d         = valid_q;
        redirect_d      = redirect_q;
        redirect_pc_d   = redirect_pc_q;
        redirect_done_d = redirect_done_q;

        if (flush3) begin
            // Data fields are don't-care in a bubble; holding them saves muxing.
            valid_d         = 1'b0;
            ctrl_d          = CTRL_BUBBLE;
            redirect_d      = 1'b0;
            redirect_done_d = 1'b0;
        end else if (stall3) begin
            // The held instruction already issued its redirect (if any), so
            // redirect_done stays set and the pulse is not repeated.
            redirect_d = 1'b0;
        end else begin
            alu_d           = ALUresult3;
            wdata_d         = Rdata23;
            waddr_d         = Wreg_addr3;
            ctrl_d          = valid3 ? ctrl_in : CTRL_BUBBLE;
            valid_d         = valid3;
            redirect_d      = taken;
            redirect_done_d = taken;
            if (taken) begin
                redirect_pc_d = target3;
            end
        end
    end

    always_ff @(negedge CLK) begin
        if (RST) begin
            alu_q           <= '0;
            wdata_q         <= '0;
            waddr_q         <= '0;
            ctrl_q          <= CTRL_BUBBLE;
            valid_q         <= 1'b0;
            redirect_q      <= 1'b0;
            redirect_pc_q   <= '0;
            redirect_done_q <= 1'b0;
        end else begin
            alu_q           <= alu_d;
            wdata_q         <= wdata_d;
            waddr_q         <= waddr_d;
            ctrl_q          <= ctrl_d;
            valid_q         <= valid_d;
            redirect_q      <= redirect_d;
            redirect_pc_q   <= redirect_pc_d;
            redirect_done_q <= redirect_done_d;
        end
    end

    // Only flush-inserted bubbles count; upstream invalid slots do not.
    sat_counter #(
        .CNT_W (CNT_W)
    ) u_bubble_cnt (
        .clk   (CLK),
        .clear (RST),
        .inc   (flush3),
        .count (bubble_cnt)
    );

    assign ALUresult3_4   = alu_q;
    assign Wdata3_4       = wdata_q;
    assign Wreg_addr3_4   = waddr_q;
    // Gating by valid guarantees an empty slot has no side effects downstream.
    assign RegWrite3_4    = ctrl_q.reg_write  & valid_q;
    assign MemWrite3_4    = ctrl_q.mem_write  & valid_q;
    assign MemRead3_4     = ctrl_q.mem_read   & valid_q;
    assign MemtoReg3_4    = ctrl_q.mem_to_reg & valid_q;
    assign valid3_4       = valid_q;
    assign redirect3_4    = redirect_q;
    assign redirect_PC3_4 = redirect_pc_q;

endmodule : third_pipe

// File: tb/tb_third_pipe.sv
// Self-checking bench for third_pipe. A behavioural model predicts the
// outputs after each falling edge; the prediction is queued when the inputs
// are driven and popped and compared after the edge. A second instance with
// a 4-bit counter shares the stimulus to exercise counter saturation.
module tb_third_pipe;

    logic        CLK = 1'b0;
    logic        RST, stall3, flush3, valid3, zero3;
    logic [31:0] ALUresult3, Rdata23, target3;
    logic [4:0]  Wreg_addr3;
    logic        JtoPC3, Branch3, RegWrite3, MemWrite3, MemRead3, MemtoReg3;

    logic [31:0] alu_o, wdata_o, pc_o;
    logic [4:0]  waddr_o;
    logic        rw_o, mw_o, mr_o, m2r_o, valid_o, redir_o;
    logic [15:0] cnt_o;

    logic [31:0] alu4_o, wdata4_o, pc4_o;
    logic [4:0]  waddr4_o;
    logic        rw4_o, mw4_o, mr4_o, m2r4_o, valid4_o, redir4_o;
    logic [3:0]  cnt4_o;

    always #5 CLK = ~CLK;

    third_pipe #(.DATA_W(32), .REG_AW(5), .CNT_W(16)) dut (
        .CLK(CLK), .RST(RST), .stall3(stall3), .flush3(flush3), .valid3(valid3),
        .ALUresult3(ALUresult3), .zero3(zero3), .Rdata23(Rdata23),
        .Wreg_addr3(Wreg_addr3), .target3(target3), .JtoPC3(JtoPC3),
        .Branch3(Branch3), .RegWrite3(RegWrite3), .MemWrite3(MemWrite3),
        .MemRead3(MemRead3), .MemtoReg3(MemtoReg3),
        .ALUresult3_4(alu_o), .Wdata3_4(wdata_o), .Wreg_addr3_4(waddr_o),
        .RegWrite3_4(rw_o), .MemWrite3_4(mw_o), .MemRead3_4(mr_o),
        .MemtoReg3_4(m2r_o), .valid3_4(valid_o), .redirect3_4(redir_o),
        .redirect_PC3_4(pc_o), .bubble_cnt(cnt_o)
    );

    third_pipe #(.DATA_W(32), .REG_AW(5), .CNT_W(4)) dut4 (
        .CLK(CLK), .RST(RST), .stall3(stall3), .flush3(flush3), .valid3(valid3),
        .ALUresult3(ALUresult3), .zero3(zero3), .Rdata23(Rdata23),
        .Wreg_addr3(Wreg_addr3), .target3(target3), .JtoPC3(JtoPC3),
        .Branch3(Branch3), .RegWrite3(RegWrite3), .MemWrite3(MemWrite3),
        .MemRead3(MemRead3), .MemtoReg3(MemtoReg3),
        .ALUresult3_4(alu4_o), .Wdata3_4(wdata4_o), .Wreg_addr3_4(waddr4_o),
        .RegWrite3_4(rw4_o), .MemWrite3_4(mw4_o), .MemRead3_4(mr4_o),
        .MemtoReg3_4(m2r4_o), .valid3_4(valid4_o), .redirect3_4(redir4_o),
        .redirect_PC3_4(pc4_o), .bubble_cnt(cnt4_o)
    );

    typedef struct {
        logic [31:0] alu;
        logic [31:0] wdata;
        logic [4:0]  waddr;
        logic [3:0]  ctrl;   // {RegWrite, MemWrite, MemRead, MemtoReg}, already valid-gated
        logic        valid;
        logic        redir;
        logic [31:0] pc;
        int          cnt;
        int          cnt4;
    } exp_t;

    exp_t exp_q[$];

    // Model state
    logic [31:0] m_alu, m_wdata, m_pc;
    logic [4:0]  m_waddr;
    logic [3:0]  m_ctrl;
    logic        m_valid, m_redir;
    int          m_cnt, m_cnt4;

    int n_checks = 0;
    int n_fail   = 0;
    int txn      = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic model_step();
        logic tk;
        exp_t e;
        if (RST) begin
            m_alu = '0; m_wdata = '0; m_waddr = '0; m_ctrl = '0;
            m_valid = 1'b0; m_redir = 1'b0; m_pc = '0; m_cnt = 0; m_cnt4 = 0;
        end else if (flush3) begin
            m_valid = 1'b0; m_ctrl = '0; m_redir = 1'b0;
            if (m_cnt < 65535) m_cnt++;
            if (m_cnt4 < 15) m_cnt4++;
        end else if (stall3) begin
            m_redir = 1'b0;
        end else begin
            tk = valid3 & ((Branch3 & zero3) | JtoPC3);
            m_alu   = ALUresult3;
            m_wdata = Rdata23;
            m_waddr = Wreg_addr3;
            m_valid = valid3;
            m_ctrl  = valid3 ? {RegWrite3, MemWrite3, MemRead3, MemtoReg3} : 4'b0;
            m_redir = tk;
            if (tk) m_pc = target3;
        end
        e.alu = m_alu; e.wdata = m_wdata; e.waddr = m_waddr; e.ctrl = m_ctrl;
        e.valid = m_valid; e.redir = m_redir; e.pc = m_pc;
        e.cnt = m_cnt; e.cnt4 = m_cnt4;
        exp_q.push_back(e);
    endtask

    // Predict, apply one falling edge, then compare every output.
    task automatic cycle();
        exp_t e;
        model_step();
        @(negedge CLK);
        #1;
        e = exp_q.pop_front();
        txn++;
        $display("txn %0d: rst=%0b fl=%0b st=%0b v=%0b -> valid=%0b ctrl=%0b%0b%0b%0b redir=%0b pc=%08h alu=%08h cnt=%0d cnt4=%0d",
                 txn, RST, flush3, stall3, valid3, valid_o, rw_o, mw_o, mr_o, m2r_o,
                 redir_o, pc_o, alu_o, cnt_o, cnt4_o);
        check_eq("alu",      alu_o,   e.alu);
        check_eq("wdata",    wdata_o, e.wdata);
        check_eq("waddr",    32'(waddr_o), 32'(e.waddr));
        check_eq("ctrl",     32'({rw_o, mw_o, mr_o, m2r_o}), 32'(e.ctrl));
        check_eq("valid",    32'(valid_o), 32'(e.valid));
        check_eq("redirect", 32'(redir_o), 32'(e.redir));
        check_eq("redir_pc", pc_o,    e.pc);
        check_eq("bubbles",  32'(cnt_o), 32'(e.cnt));
        check_eq("bubbles4", 32'(cnt4_o), 32'(e.cnt4));
        check_eq("ctrl4",    32'({rw4_o, mw4_o, mr4_o, m2r4_o, valid4_o, redir4_o}),
                             32'({rw_o, mw_o, mr_o, m2r_o, valid_o, redir_o}));
    endtask

    task automatic idle_inputs();
        stall3 = 1'b0; flush3 = 1'b0; valid3 = 1'b0; zero3 = 1'b0;
        ALUresult3 = '0; Rdata23 = '0; target3 = '0; Wreg_addr3 = '0;
        JtoPC3 = 1'b0; Branch3 = 1'b0; RegWrite3 = 1'b0; MemWrite3 = 1'b0;
        MemRead3 = 1'b0; MemtoReg3 = 1'b0;
    endtask

    task automatic random_inputs();
        valid3 = 1'($urandom_range(0, 1)); zero3 = 1'($urandom_range(0, 1));
        ALUresult3 = $urandom; Rdata23 = $urandom; target3 = $urandom;
        Wreg_addr3 = 5'($urandom_range(0, 31));
        JtoPC3 = 1'($urandom_range(0, 1)); Branch3 = 1'($urandom_range(0, 1));
        RegWrite3 = 1'($urandom_range(0, 1)); MemWrite3 = 1'($urandom_range(0, 1));
        MemRead3 = 1'($urandom_range(0, 1)); MemtoReg3 = 1'($urandom_range(0, 1));
    endtask

    initial begin
        #200000;
        n_checks++;
        n_fail++;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int pulses;
        m_alu = '0; m_wdata = '0; m_waddr = '0; m_ctrl = '0;
        m_valid = 1'b0; m_redir = 1'b0; m_pc = '0; m_cnt = 0; m_cnt4 = 0;

        // Reset with random inputs, including flush/stall, for two edges.
        RST = 1'b1;
        random_inputs();
        stall3 = 1'b1; flush3 = 1'b1;
        cycle();
        random_inputs();
        cycle();
        check_eq("rst_valid", 32'(valid_o), 32'd0);
        check_eq("rst_cnt",   32'(cnt_o),   32'd0);

        // First instruction after reset.
        RST = 1'b0;
        idle_inputs();
        valid3 = 1'b1; RegWrite3 = 1'b1; ALUresult3 = 32'h0000_0010;
        cycle();
        check_eq("first_alu", alu_o, 32'h0000_0010);
        check_eq("first_rw",  32'(rw_o), 32'd1);

        // Taken branch, then a three-edge stall with scrambled upstream data.
        idle_inputs();
        valid3 = 1'b1; Branch3 = 1'b1; zero3 = 1'b1; target3 = 32'h0040_0020;
        ALUresult3 = 32'h0000_1234; Wreg_addr3 = 5'd7; RegWrite3 = 1'b1;
        cycle();
        pulses = int'(redir_o);
        for (int i = 0; i < 3; i++) begin
            random_inputs();
            stall3 = 1'b1;
            cycle();
            pulses += int'(redir_o);
        end
        check_eq("branch_pulses", 32'(pulses), 32'd1);
        check_eq("branch_pc",     pc_o, 32'h0040_0020);
        check_eq("stall_alu",     alu_o, 32'h0000_1234);
        check_eq("stall_waddr",   32'(waddr_o), 32'd7);

        // Branch not taken; jump in an invalid slot.
        idle_inputs();
        valid3 = 1'b1; Branch3 = 1'b1; zero3 = 1'b0; target3 = 32'h0000_0bad;
        cycle();
        check_eq("not_taken", 32'(redir_o), 32'd0);
        idle_inputs();
        valid3 = 1'b0; JtoPC3 = 1'b1; target3 = 32'h0000_0bad; RegWrite3 = 1'b1;
        cycle();
        check_eq("jump_invalid", 32'(redir_o), 32'd0);
        check_eq("invalid_rw",   32'(rw_o),    32'd0);
        check_eq("pc_kept",      pc_o, 32'h0040_0020);

        // Store held by a stall, then flush+stall together.
        idle_inputs();
        valid3 = 1'b1; MemWrite3 = 1'b1; Rdata23 = 32'h1111_2222;
        cycle();
        stall3 = 1'b1;
        cycle();
        check_eq("held_store", 32'(mw_o), 32'd1);
        stall3 = 1'b1; flush3 = 1'b1;
        cycle();
        check_eq("flush_mw",    32'(mw_o),    32'd0);
        check_eq("flush_valid", 32'(valid_o), 32'd0);
        check_eq("flush_cnt",   32'(cnt_o),   32'd1);

        // Store data capture.
        idle_inputs();
        valid3 = 1'b1; MemWrite3 = 1'b1; Rdata23 = 32'hDEAD_BEEF;
        ALUresult3 = 32'h1000_0004;
        cycle();
        check_eq("store_wdata", wdata_o, 32'hDEAD_BEEF);
        check_eq("store_addr",  alu_o,   32'h1000_0004);
        check_eq("store_mw",    32'(mw_o), 32'd1);

        // Twenty flushes: the 4-bit counter sticks at 15.
        for (int i = 0; i < 20; i++) begin
            random_inputs();
            flush3 = 1'b1; stall3 = 1'($urandom_range(0, 1));
            cycle();
        end
        check_eq("sat4",  32'(cnt4_o), 32'd15);
        check_eq("cnt16", 32'(cnt_o),  32'd21);
        idle_inputs();
        RST = 1'b1;
        cycle();
        check_eq("sat4_rst", 32'(cnt4_o), 32'd0);
        RST = 1'b0;

        // Random mix of load/stall/flush.
        for (int i = 0; i < 60; i++) begin
            random_inputs();
            stall3 = ($urandom_range(0, 3) == 0);
            flush3 = ($urandom_range(0, 5) == 0);
            cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_third_pipe
